fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage for the pipelined MIPS datapath, the next step after the single-cycle core. It owns the program counter and the PC+4 adder, and drives the instruction-memory address. It takes the branch redirect (zero flag AND branch) from downstream, and registers the fetched instruction into the IF/ID pipeline register that feeds decode (register file, control unit, ALU control). It supports stall and flush so that a later hazard unit can plug in without rework.

Parameters:
WIDTH, 32, datapath/address width in bits.
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP, 32'h0000_0000, instruction word inserted into IF/ID on a bubble (sll $0,$0,0).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
stall  in  1  hold PC and IF/ID contents this cycle.
flush  in  1  squash the IF/ID entry (insert NOP bubble).
branch_taken  in  1  redirect request; the upstream computes it as zflag & branch.
branch_target  in  WIDTH  redirect address; PC+4 + (sign-extended imm << 2).
imem_addr  out  WIDTH  instruction-memory address (combinational memory), equal to pc.
imem_instr  in  WIDTH  instruction word returned for imem_addr, same cycle.
pc  out  WIDTH  current PC.
id_instr  out  WIDTH  IF/ID registered instruction.
id_pc4  out  WIDTH  IF/ID registered PC+4 of that instruction.
id_valid  out  1  IF/ID entry holds a real instruction.
fetch_count  out  WIDTH  number of instructions accepted into IF/ID.

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect) sets:
  - pc=RESET_PC, id_instr=NOP, id_pc4=0, id_valid=0, fetch_count=0.
  - state=BOOT.
- The FSM has two states, BOOT and RUN.
  - BOOT lasts exactly one rising edge after rst deasserts.
  - On that edge: pc unchanged, IF/ID stays a bubble, and the state moves to RUN. No input is sampled in BOOT, including branch_taken, stall and flush.
  - The BOOT edge leaves a settle slot for a future synchronous imem.
- In RUN, the following is evaluated at each rising edge in priority order:
  1. branch_taken=1:
     - pc <= {branch_target[WIDTH-1:2],2'b00}. The low two bits are forced to zero.
     - IF/ID <= bubble (id_instr=NOP, id_valid=0, id_pc4 holds).
     - Overrides stall and flush.
  2. flush=1 (no branch):
     - IF/ID <= bubble.
     - pc <= pc if stall=1, else pc+4.
  3. stall=1:
     - pc, id_instr, id_pc4, id_valid and fetch_count all hold.
  4. Otherwise:
     - pc <= pc+4.
     - id_instr <= imem_instr, id_pc4 <= pc+4, id_valid <= 1.
     - fetch_count <= fetch_count+1.
- Fetch latency: an instruction at address A appears on id_instr one edge after pc=A with no stall, flush or branch.
- Arithmetic:
  - pc+4 is modulo 2^WIDTH; 32'hFFFF_FFFC+4 wraps to 0, with no flag.
  - fetch_count wraps modulo 2^WIDTH.
  - fetch_count increments only in case 4.
- imem_addr is a pure wire of pc; no gating.
- pc[1:0] is always 00 after reset.
- Outputs change only on the rising edge of clk or on assertion of rst.

Test Plan:
- Reset/boot: assert rst, release before edge 0; imem returns addr-based words.
  -> After edge 0: pc=0, id_valid=0.
  -> After edge 1: id_instr=mem[0], id_pc4=4, id_valid=1, pc=8? No: pc=4. After edge 2: pc=8, fetch_count=2.
- Straight-line fetch: 5 free-running edges in RUN from pc=0.
  -> id_pc4 sequence 4, 8, 12, 16, 20.
  -> id_instr = mem[pc] of the prior cycle.
  -> fetch_count=5.
- Stall: stall=1 for 3 edges with pc=0x10.
  -> pc stays 0x10; id_instr, id_pc4, fetch_count unchanged.
  -> On release, the next edge gives pc=0x14, id_instr=mem[0x10].
- Branch vs stall: pc=0x20, branch_taken=1, branch_target=0x0000_0047, stall=1.
  -> pc=0x44, id_valid=0, id_instr=NOP.
  -> Next normal edge: id_instr=mem[0x44], id_pc4=0x48.
- Flush+stall and wrap:
  - flush=1 with stall=1 at pc=0x30 -> pc=0x30, id_valid=0.
  - Redirect to 0xFFFF_FFFC, then one normal edge -> pc=0x0, id_pc4=0x0.
- Async reset mid-run: rst pulse between edges while pc=0x40 and id_valid=1.
  -> All outputs reset immediately, without waiting for a clock edge.
  -> BOOT is repeated: id_valid=0 for the first edge after release.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC and the PC+4 adder, registers fetched words into IF/ID.
// Latency: one edge from pc=A to the word at A appearing on id_instr. The first edge after reset is a BOOT slot.
// Backpressure: stall holds PC and IF/ID. Flush inserts a bubble. A taken branch redirects the PC and overrides both.
module fetch_stage #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [WIDTH-1:0] NOP      = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_instr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] id_instr,
    output logic [WIDTH-1:0] id_pc4,
    output logic             id_valid,
    output logic [WIDTH-1:0] fetch_count
);

    localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

    state_t           state;
    logic [WIDTH-1:0] pc_plus4;

    // Sequential PC increment. It wraps modulo 2^WIDTH and has no carry out.
    assign pc_plus4  = pc + FOUR;

    // The memory is combinational, so the fetch address is the PC itself.
    assign imem_addr = pc;

    // Fetch FSM with registered PC and IF/ID outputs. Inputs are checked in the order branch, flush, stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            id_instr    <= NOP;
            id_pc4      <= '0;
            id_valid    <= 1'b0;
            fetch_count <= '0;
        end else begin
            case (state)
                // BOOT ignores every input. This leaves a settle slot for a future synchronous imem.
                BOOT: begin
                    state <= RUN;
                end
                RUN: begin
                    if (branch_taken) begin
                        // Force word alignment so pc[1:0] stays 00.
                        pc       <= {branch_target[WIDTH-1:2], 2'b00};
                        id_instr <= NOP;
                        id_valid <= 1'b0;
                    end else if (flush) begin
                        id_instr <= NOP;
                        id_valid <= 1'b0;
                        if (!stall) begin
                            pc <= pc_plus4;
                        end
                    end else if (!stall) begin
                        pc          <= pc_plus4;
                        id_instr    <= imem_instr;
                        id_pc4      <= pc_plus4;
                        id_valid    <= 1'b1;
                        fetch_count <= fetch_count + ONE;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. The instruction memory returns address-derived words.
// Expected values are hand-computed from the fetch rules.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_fetch_stage;

    localparam logic [31:0] MEM_KEY = 32'hDEAD_BEEF;
    localparam logic [31:0] NOP_W   = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_stage #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000),
        .NOP      (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .pc            (pc),
        .id_instr      (id_instr),
        .id_pc4        (id_pc4),
        .id_valid      (id_valid),
        .fetch_count   (fetch_count)
    );

    // Combinational instruction memory: each word is its address XOR a fixed key.
    assign imem_instr = imem_addr ^ MEM_KEY;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ MEM_KEY;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the whole visible state in one call.
    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic [31:0] e_pc4, input logic e_vld, input logic [31:0] e_cnt);
        check({tag, ".pc"},    pc,                e_pc);
        check({tag, ".addr"},  imem_addr,         e_pc);
        check({tag, ".instr"}, id_instr,          e_instr);
        check({tag, ".pc4"},   id_pc4,            e_pc4);
        check({tag, ".vld"},   {31'd0, id_valid}, {31'd0, e_vld});
        check({tag, ".cnt"},   fetch_count,       e_cnt);
    endtask

    initial begin
        rst           = 1'b1;
        stall         = 1'b0;
        flush         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;

        // Reset state while rst is held.
        #3;
        check_all("reset", 32'h0, NOP_W, 32'h0, 1'b0, 32'd0);

        // Release reset before edge 0. A branch request during BOOT must be ignored.
        #9;
        rst           = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0100;
        tick();
        check_all("boot", 32'h0, NOP_W, 32'h0, 1'b0, 32'd0);
        branch_taken  = 1'b0;

        // Straight-line fetch from pc=0.
        tick();
        check_all("run1", 32'h4, mem_word(32'h0), 32'h4, 1'b1, 32'd1);
        tick();
        check_all("run2", 32'h8, mem_word(32'h4), 32'h8, 1'b1, 32'd2);
        tick();
        check_all("run3", 32'hC, mem_word(32'h8), 32'hC, 1'b1, 32'd3);
        tick();
        check_all("run4", 32'h10, mem_word(32'hC), 32'h10, 1'b1, 32'd4);

        // Stall for 3 edges at pc=0x10. Everything holds.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("stall", 32'h10, mem_word(32'hC), 32'h10, 1'b1, 32'd4);
        end
        stall = 1'b0;
        tick();
        check_all("unstall", 32'h14, mem_word(32'h10), 32'h14, 1'b1, 32'd5);

        // Advance to pc=0x20.
        tick();
        tick();
        tick();
        check_all("to20", 32'h20, mem_word(32'h1C), 32'h20, 1'b1, 32'd8);

        // Branch overrides stall. The low target bits are forced to zero.
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0047;
        stall         = 1'b1;
        tick();
        check_all("brstall", 32'h44, NOP_W, 32'h20, 1'b0, 32'd8);
        branch_taken = 1'b0;
        stall        = 1'b0;
        tick();
        check_all("postbr", 32'h48, mem_word(32'h44), 32'h48, 1'b1, 32'd9);

        // Redirect to 0x30, then flush together with stall.
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0030;
        tick();
        check_all("br30", 32'h30, NOP_W, 32'h48, 1'b0, 32'd9);
        branch_taken = 1'b0;
        flush        = 1'b1;
        stall        = 1'b1;
        tick();
        check_all("flstall", 32'h30, NOP_W, 32'h48, 1'b0, 32'd9);

        // Flush alone still advances the PC.
        stall = 1'b0;
        tick();
        check_all("flush", 32'h34, NOP_W, 32'h48, 1'b0, 32'd9);
        flush = 1'b0;

        // Flush overrides a normal fetch even when valid was 1.
        tick();
        check_all("refill", 32'h38, mem_word(32'h34), 32'h38, 1'b1, 32'd10);
        flush = 1'b1;
        tick();
        check_all("flushv", 32'h3C, NOP_W, 32'h38, 1'b0, 32'd10);
        flush = 1'b0;

        // Wrap: redirect to 0xFFFF_FFFC (target 0xFFFF_FFFE is aligned down), then one normal edge.
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFE;
        tick();
        check_all("brtop", 32'hFFFF_FFFC, NOP_W, 32'h38, 1'b0, 32'd10);
        branch_taken = 1'b0;
        tick();
        check_all("wrap", 32'h0, mem_word(32'hFFFF_FFFC), 32'h0, 1'b1, 32'd11);

        // Get to pc=0x40 with a valid entry.
        branch_taken  = 1'b1;
        branch_target = 32'h0000_003C;
        tick();
        branch_taken  = 1'b0;
        tick();
        check_all("at40", 32'h40, mem_word(32'h3C), 32'h40, 1'b1, 32'd12);

        // Async reset pulse between edges. The outputs clear with no clock edge.
        #2;
        rst = 1'b1;
        #1;
        check_all("arst", 32'h0, NOP_W, 32'h0, 1'b0, 32'd0);
        rst = 1'b0;

        // BOOT repeats, then fetching resumes.
        tick();
        check_all("reboot", 32'h0, NOP_W, 32'h0, 1'b0, 32'd0);
        tick();
        check_all("refetch", 32'h4, mem_word(32'h0), 32'h4, 1'b1, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
